// File: rtl/id_stage_regd.sv
// id_stage_regd -- decode stage of the ARM-subset 5-stage pipeline.
//
// Holds the register file, the condition check, the control decode and the
// ID/EXE pipeline register. The WB stage writes back through wb_*. A hazard,
// a flush or an empty IF/ID slot turns the EXE slot into a bubble. An
// instruction whose condition fails still occupies the EXE slot, but all of
// its controls are cleared, so it retires as a NOP.
//
// Optional build macro: ID_WB_BYPASS_EN. When it is defined, a same-cycle
// writeback to a source register is forwarded into val_rn/val_rm. When it is
// undefined, those reads return the pre-write register contents.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid            IF/ID slot holds a real instruction
//   instruction, pc_in  instruction and its PC from IF/ID
//   hazard, flush       stall request / branch-taken kill (both give a bubble)
//   wb_en/dest/value    register file writeback port
//   sr                  status flags {N,Z,C,V}
//   src1, src2, two_src combinational source-register info for the hazard unit
//   out_*, controls,    registered ID/EXE fields (1-cycle latency)
//   operands, fields
module id_stage_regd #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 15,
   parameter int RA_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              hazard,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [RA_W-1:0]   wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   input  logic [3:0]        sr,
   output logic [RA_W-1:0]   src1,
   output logic [RA_W-1:0]   src2,
   output logic              two_src,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_pc,
   output logic              wb_en_o,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              b,
   output logic              s,
   output logic [3:0]        exe_cmd,
   output logic [DATA_W-1:0] val_rn,
   output logic [DATA_W-1:0] val_rm,
   output logic              imm,
   output logic [11:0]       shift_operand,
   output logic [23:0]       signed_imm_24,
   output logic [RA_W-1:0]   dest
);

   logic [DATA_W-1:0] rf_reg [NUM_REGS];
   logic [DATA_W-1:0] rn_val, rm_val;
   logic [1:0]        mode;
   logic [3:0]        opcode;
   logic              s_bit, is_str, cond_ok;
   logic              d_wb, d_mr, d_mw, d_b, d_s;
   logic [3:0]        d_cmd;

   assign mode    = instruction[27:26];
   assign opcode  = instruction[24:21];
   assign s_bit   = instruction[20];
   assign is_str  = (mode == 2'b01) && !s_bit;
   assign src1    = instruction[19:16];
   assign src2    = is_str ? instruction[15:12] : instruction[3:0];
   assign two_src = !instruction[25] || is_str;

   // Register file. Reset loads each register with its own index. Writes to
   // addresses past the last register fall through the loop and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= DATA_W'(i);
      end else if (wb_en) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (int'(wb_dest) == i) rf_reg[i] <= wb_value;
      end
   end

   // Operand reads. Addresses past the last register read as 0.
   always_comb begin
      rn_val = '0;
      rm_val = '0;
      if (int'(src1) < NUM_REGS) rn_val = rf_reg[src1];
      if (int'(src2) < NUM_REGS) rm_val = rf_reg[src2];
`ifdef ID_WB_BYPASS_EN
      if (wb_en && wb_dest == src1 && int'(src1) < NUM_REGS) rn_val = wb_value;
      if (wb_en && wb_dest == src2 && int'(src2) < NUM_REGS) rm_val = wb_value;
`endif
   end

   // Condition check against {N,Z,C,V}.
   always_comb begin
      cond_ok = 1'b0;
      case (instruction[31:28])
         4'h0: cond_ok = sr[2];
         4'h1: cond_ok = !sr[2];
         4'h2: cond_ok = sr[1];
         4'h3: cond_ok = !sr[1];
         4'h4: cond_ok = sr[3];
         4'h5: cond_ok = !sr[3];
         4'h6: cond_ok = sr[0];
         4'h7: cond_ok = !sr[0];
         4'h8: cond_ok = sr[1] && !sr[2];
         4'h9: cond_ok = !sr[1] || sr[2];
         4'hA: cond_ok = sr[3] == sr[0];
         4'hB: cond_ok = sr[3] != sr[0];
         4'hC: cond_ok = !sr[2] && (sr[3] == sr[0]);
         4'hD: cond_ok = sr[2] || (sr[3] != sr[0]);
         4'hE: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // Control decode. Unlisted mode/opcode combinations leave every control 0.
   always_comb begin
      d_wb  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_b   = 1'b0;
      d_s   = 1'b0;
      d_cmd = 4'h0;
      case (mode)
         2'b00: begin
            d_wb = 1'b1;
            d_s  = s_bit;
            case (opcode)
               4'b1101: d_cmd = 4'b0001;
               4'b1111: d_cmd = 4'b1001;
               4'b0100: d_cmd = 4'b0010;
               4'b0101: d_cmd = 4'b0011;
               4'b0010: d_cmd = 4'b0100;
               4'b0110: d_cmd = 4'b0101;
               4'b0000: d_cmd = 4'b0110;
               4'b1100: d_cmd = 4'b0111;
               4'b0001: d_cmd = 4'b1000;
               // Compares update the flags only and never write a register.
               4'b1010: begin d_cmd = 4'b0100; d_wb = 1'b0; d_s = 1'b1; end
               4'b1000: begin d_cmd = 4'b0110; d_wb = 1'b0; d_s = 1'b1; end
               default: begin d_wb = 1'b0; d_s = 1'b0; end
            endcase
         end
         2'b01: begin
            d_cmd = 4'b0010;
            d_mr  = s_bit;
            d_wb  = s_bit;
            d_mw  = !s_bit;
         end
         2'b10: d_b = 1'b1;
         default: ;
      endcase
   end

   // ID/EXE register. A kill (reset, flush, hazard or empty slot) clears
   // everything. A failed condition keeps the slot valid but clears the
   // controls.
   always_ff @(posedge clk) begin
      if (rst || flush || hazard || !in_valid) begin
         out_valid     <= 1'b0;
         out_pc        <= '0;
         wb_en_o       <= 1'b0;
         mem_r_en      <= 1'b0;
         mem_w_en      <= 1'b0;
         b             <= 1'b0;
         s             <= 1'b0;
         exe_cmd       <= 4'h0;
         val_rn        <= '0;
         val_rm        <= '0;
         imm           <= 1'b0;
         shift_operand <= '0;
         signed_imm_24 <= '0;
         dest          <= '0;
      end else begin
         out_valid     <= 1'b1;
         out_pc        <= pc_in;
         wb_en_o       <= cond_ok && d_wb;
         mem_r_en      <= cond_ok && d_mr;
         mem_w_en      <= cond_ok && d_mw;
         b             <= cond_ok && d_b;
         s             <= cond_ok && d_s;
         exe_cmd       <= cond_ok ? d_cmd : 4'h0;
         val_rn        <= rn_val;
         val_rm        <= rm_val;
         imm           <= instruction[25];
         shift_operand <= instruction[11:0];
         signed_imm_24 <= instruction[23:0];
         dest          <= instruction[15:12];
      end
   end

endmodule
